pc_sequencer: RTL and testbench

//  Owns the program counter (PC) of the MIPS core and sequences instruction fetch.

---
 rtl/mips_pkg.sv | 29 ++
 rtl/pc_next_select.sv | 59 +++++
 rtl/pc_sequencer.sv | 128 ++++++++++++
 tb/tb_pc_sequencer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS front end.
package mips_pkg;

    // Default PC loaded on reset and default exception target.
    localparam logic [31:0] DEF_RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_0080;

    // Fetch sequencer states.
    typedef enum logic [1:0] {
        BOOT,
        FETCH,
        STALLED
    } state_e;

    // Where the next PC came from.
    typedef enum logic [2:0] {
        SRC_SEQ,
        SRC_BR,
        SRC_JMP,
        SRC_EXC,
        SRC_PEND
    } src_e;

    // Instruction addresses are word aligned; low two bits are dropped.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_next_select.sv
// Priority selector for the next program counter.
// o_new_* describes the highest-priority redirect arriving this cycle (pending ignored);
// o_next_* is the PC to load on a fetch accept, including pending and pc+4.
module pc_next_select
    import mips_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
    input  logic [31:0] i_pc_plus_four,
    input  logic        i_exception,
    input  logic        i_jump_valid,
    input  logic [31:0] i_jump_target,
    input  logic        i_branch_valid,
    input  logic [31:0] i_branch_target,
    input  logic        i_pend_valid,
    input  logic        i_pend_exc,
    input  logic [31:0] i_pend_target,
    output logic [31:0] o_next_pc,
    output src_e        o_next_src,
    output logic        o_new_valid,
    output src_e        o_new_src,
    output logic [31:0] o_new_target
);

    logic w_new_wins;

    // Highest-priority incoming redirect: exception > jump > branch.
    always_comb begin
        o_new_valid  = i_exception | i_jump_valid | i_branch_valid;
        o_new_src    = SRC_SEQ;
        o_new_target = i_pc_plus_four;
        if (i_exception) begin
            o_new_src    = SRC_EXC;
            o_new_target = align_word(EXC_VECTOR);
        end else if (i_jump_valid) begin
            o_new_src    = SRC_JMP;
            o_new_target = align_word(i_jump_target);
        end else if (i_branch_valid) begin
            o_new_src    = SRC_BR;
            o_new_target = align_word(i_branch_target);
        end
    end

    // A buffered exception still outranks a fresh jump or branch.
    always_comb begin
        w_new_wins = o_new_valid & (i_exception | ~(i_pend_valid & i_pend_exc));
        if (w_new_wins) begin
            o_next_pc  = o_new_target;
            o_next_src = o_new_src;
        end else if (i_pend_valid) begin
            o_next_pc  = i_pend_target;
            o_next_src = SRC_PEND;
        end else begin
            o_next_pc  = i_pc_plus_four;
            o_next_src = SRC_SEQ;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner and instruction fetch sequencer.
// Holds the PC, runs the BOOT/FETCH/STALLED handshake FSM and buffers redirects
// that arrive while a fetch request is waiting for imem.
module pc_sequencer
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
    parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        fetchReady,
    output logic        fetchReq,
    output logic [31:0] fetchAddr,
    input  logic        exception,
    input  logic        jumpValid,
    input  logic [31:0] jumpTarget,
    input  logic        branchValid,
    input  logic [31:0] branchTarget,
    output logic [31:0] pc,
    output logic [31:0] pcPlusFour,
    output logic        redirectTaken
);

    state_e      r_state;
    state_e      w_state_next;
    logic [31:0] r_pc;
    logic        r_pend_valid;
    logic        r_pend_exc;
    logic [31:0] r_pend_target;
    logic        r_redirect;

    logic [31:0] w_pc_plus_four;
    logic        w_fetch_req;
    logic        w_accept;
    logic [31:0] w_next_pc;
    src_e        w_next_src;
    logic        w_new_valid;
    src_e        w_new_src;
    logic [31:0] w_new_target;

    assign w_pc_plus_four = r_pc + 32'd4;
    assign w_fetch_req    = (r_state == FETCH);
    assign w_accept       = w_fetch_req & fetchReady;

    pc_next_select #(
        .EXC_VECTOR (EXC_VECTOR)
    ) u_next_select (
        .i_pc_plus_four  (w_pc_plus_four),
        .i_exception     (exception),
        .i_jump_valid    (jumpValid),
        .i_jump_target   (jumpTarget),
        .i_branch_valid  (branchValid),
        .i_branch_target (branchTarget),
        .i_pend_valid    (r_pend_valid),
        .i_pend_exc      (r_pend_exc),
        .i_pend_target   (r_pend_target),
        .o_next_pc       (w_next_pc),
        .o_next_src      (w_next_src),
        .o_new_valid     (w_new_valid),
        .o_new_src       (w_new_src),
        .o_new_target    (w_new_target)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= BOOT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state: stall only takes effect once the outstanding request is accepted.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            BOOT:    w_state_next = stall ? STALLED : FETCH;
            FETCH:   if (w_accept && stall) w_state_next = STALLED;
            STALLED: if (!stall) w_state_next = FETCH;
            default: w_state_next = BOOT;
        endcase
    end

    // FSM outputs; fetchReq falls with the asynchronous reset through r_state.
    always_comb begin
        fetchReq      = w_fetch_req;
        fetchAddr     = r_pc;
        pc            = r_pc;
        pcPlusFour    = w_pc_plus_four;
        redirectTaken = r_redirect;
    end

    // PC, pending-redirect buffer and redirect pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_pend_valid  <= 1'b0;
            r_pend_exc    <= 1'b0;
            r_pend_target <= '0;
            r_redirect    <= 1'b0;
        end else begin
            r_redirect <= 1'b0;
            if (r_state == FETCH) begin
                if (w_accept) begin
                    r_pc         <= w_next_pc;
                    r_pend_valid <= 1'b0;
                    r_pend_exc   <= 1'b0;
                    r_redirect   <= (w_next_src != SRC_SEQ);
                end else if (w_new_valid &&
                             !(r_pend_valid && r_pend_exc && w_new_src != SRC_EXC)) begin
                    // Request must stay stable, so park the redirect until accept.
                    r_pend_valid  <= 1'b1;
                    r_pend_exc    <= (w_new_src == SRC_EXC);
                    r_pend_target <= w_new_target;
                end
            end else if (w_new_valid) begin
                // No request outstanding: redirect straight into the PC.
                r_pc         <= w_new_target;
                r_pend_valid <= 1'b0;
                r_pend_exc   <= 1'b0;
                r_redirect   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus random traffic,
// all compared each cycle against a behavioural model of the fetch rules.
module tb_pc_sequencer;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] EXC_PC = 32'h0000_0080;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        fetchReady;
    logic        fetchReq;
    logic [31:0] fetchAddr;
    logic        exception;
    logic        jumpValid;
    logic [31:0] jumpTarget;
    logic        branchValid;
    logic [31:0] branchTarget;
    logic [31:0] pc;
    logic [31:0] pcPlusFour;
    logic        redirectTaken;

    int checks   = 0;
    int failures = 0;

    // Model state: mode 0 = boot, 1 = fetching, 2 = stalled.
    int          m_mode;
    logic [31:0] m_pc;
    logic        m_pend;
    logic        m_pend_exc;
    logic [31:0] m_pend_tgt;
    logic        m_redir;

    pc_sequencer #(
        .RESET_PC   (RST_PC),
        .EXC_VECTOR (EXC_PC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .fetchReady    (fetchReady),
        .fetchReq      (fetchReq),
        .fetchAddr     (fetchAddr),
        .exception     (exception),
        .jumpValid     (jumpValid),
        .jumpTarget    (jumpTarget),
        .branchValid   (branchValid),
        .branchTarget  (branchTarget),
        .pc            (pc),
        .pcPlusFour    (pcPlusFour),
        .redirectTaken (redirectTaken)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode     = 0;
        m_pc       = RST_PC;
        m_pend     = 1'b0;
        m_pend_exc = 1'b0;
        m_pend_tgt = '0;
        m_redir    = 1'b0;
    endtask

    // One rising edge worth of architectural behaviour.
    task automatic model_edge();
        logic        any;
        logic        is_exc;
        logic [31:0] tgt;
        logic        redir;
        any    = exception | jumpValid | branchValid;
        is_exc = exception;
        tgt    = exception ? EXC_PC : (jumpValid ? jumpTarget : branchTarget);
        tgt    = tgt & ~32'h3;
        redir  = 1'b0;
        if (m_mode == 1) begin
            if (fetchReady) begin
                if (any && (is_exc || !(m_pend && m_pend_exc))) begin
                    m_pc  = tgt;
                    redir = 1'b1;
                end else if (m_pend) begin
                    m_pc  = m_pend_tgt;
                    redir = 1'b1;
                end else begin
                    m_pc = m_pc + 32'd4;
                end
                m_pend     = 1'b0;
                m_pend_exc = 1'b0;
                m_mode     = stall ? 2 : 1;
            end else if (any && !(m_pend && m_pend_exc && !is_exc)) begin
                m_pend     = 1'b1;
                m_pend_exc = is_exc;
                m_pend_tgt = tgt;
            end
        end else begin
            if (any) begin
                m_pc       = tgt;
                m_pend     = 1'b0;
                m_pend_exc = 1'b0;
                redir      = 1'b1;
            end
            if (m_mode == 0) m_mode = stall ? 2 : 1;
            else if (!stall) m_mode = 1;
        end
        m_redir = redir;
    endtask

    // Drive one cycle's inputs (from posedge+1), check at negedge, advance model at posedge.
    task automatic step(input logic st, input logic fr, input logic ex,
                        input logic jv, input logic [31:0] jt,
                        input logic bv, input logic [31:0] bt);
        stall        = st;
        fetchReady   = fr;
        exception    = ex;
        jumpValid    = jv;
        jumpTarget   = jt;
        branchValid  = bv;
        branchTarget = bt;
        @(negedge clk);
        chk("fetchReq", {31'd0, fetchReq}, {31'd0, m_mode == 1});
        chk("fetchAddr", fetchAddr, m_pc);
        chk("pc", pc, m_pc);
        chk("pcPlusFour", pcPlusFour, m_pc + 32'd4);
        chk("redirectTaken", {31'd0, redirectTaken}, {31'd0, m_redir});
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle(input logic st, input logic fr);
        step(st, fr, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    endtask

    initial begin
        rst_n        = 1'b0;
        stall        = 1'b0;
        fetchReady   = 1'b0;
        exception    = 1'b0;
        jumpValid    = 1'b0;
        jumpTarget   = '0;
        branchValid  = 1'b0;
        branchTarget = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_fetchReq", {31'd0, fetchReq}, 32'd0);
        chk("rst_pc", pc, RST_PC);
        chk("rst_redirect", {31'd0, redirectTaken}, 32'd0);
        rst_n = 1'b1;

        // 1: boot then sequential fetch
        idle(1'b0, 1'b1);
        chk("t1_addr0", fetchAddr, 32'h0);
        idle(1'b0, 1'b1);
        chk("t1_addr4", fetchAddr, 32'h4);
        idle(1'b0, 1'b1);
        chk("t1_addr8", fetchAddr, 32'h8);
        chk("t1_redirect", {31'd0, redirectTaken}, 32'd0);
        idle(1'b0, 1'b1);
        idle(1'b0, 1'b1);
        chk("t2_pc10", pc, 32'h10);

        // 2: request held while not ready, stall waits for accept
        repeat (3) begin
            idle(1'b1, 1'b0);
            chk("t2_hold_req", {31'd0, fetchReq}, 32'd1);
            chk("t2_hold_addr", fetchAddr, 32'h10);
        end
        idle(1'b1, 1'b1);
        chk("t2_stalled_req", {31'd0, fetchReq}, 32'd0);
        chk("t2_pc14", pc, 32'h14);
        idle(1'b0, 1'b0);

        // 3: jump buffered while not ready
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h400, 1'b0, 32'd0);
        chk("t3_held", pc, 32'h14);
        idle(1'b0, 1'b1);
        chk("t3_pc400", pc, 32'h400);
        chk("t3_pulse", {31'd0, redirectTaken}, 32'd1);
        idle(1'b0, 1'b0);
        chk("t3_pulse_end", {31'd0, redirectTaken}, 32'd0);

        // 4: priority and sticky pending exception
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'h200, 1'b1, 32'h300);
        chk("t4_exc", pc, 32'h80);
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h200, 1'b1, 32'h300);
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h200, 1'b0, 32'd0);
        idle(1'b0, 1'b1);
        chk("t4_pend_exc", pc, 32'h80);

        // 5: wrap and alignment
        step(1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'd0);
        chk("t5_top", pc, 32'hFFFF_FFFC);
        idle(1'b0, 1'b1);
        chk("t5_wrap", pc, 32'h0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 32'h103);
        chk("t5_align", pc, 32'h100);

        // 6: reset while a pending redirect waits
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h500, 1'b0, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_req_drop", {31'd0, fetchReq}, 32'd0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(1'b0, 1'b1);
        idle(1'b0, 1'b1);
        chk("t6_no_pend", pc, 32'h4);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic ex, jv, bv;
            ex = ($urandom_range(0, 19) == 0);
            jv = ($urandom_range(0, 7) == 0);
            bv = ($urandom_range(0, 5) == 0);
            step($urandom_range(0, 3) == 0, $urandom_range(0, 9) < 6, ex,
                 jv, $urandom(), bv, $urandom());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
